brick_game_ctrl_fsm: RTL and testbench



---
 rtl/brick_game_pkg.sv | 35 +++
 rtl/bcd_score_counter.sv | 41 ++++
 rtl/brick_game_ctrl_fsm.sv | 108 ++++++++++
 tb/tb_brick_game_ctrl_fsm.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/brick_game_pkg.sv
// Shared game-flow types: 3-bit state encoding, overlay flag bundle, default life count.
// The overlay decode is a pure function so the FSM and any future debug view agree.
package brick_game_pkg;

  typedef enum logic [2:0] {
    ST_NEWGAME = 3'd0,
    ST_PLAY    = 3'd1,
    ST_NEWBALL = 3'd2,
    ST_OVER    = 3'd3,
    ST_WIN     = 3'd4
  } state_t;

  typedef struct packed {
    logic graph_still;
    logic ball_reset;
    logic game_over;
    logic game_win;
  } ovl_t;

  localparam int unsigned LIVES_INIT_DEF = 3;

  function automatic ovl_t decode_ovl(input state_t s);
    ovl_t o;
    o = '{graph_still: 1'b1, ball_reset: 1'b1, game_over: 1'b0, game_win: 1'b0};
    case (s)
      ST_PLAY:    o = '{graph_still: 1'b0, ball_reset: 1'b0, game_over: 1'b0, game_win: 1'b0};
      ST_NEWBALL: o = '{graph_still: 1'b1, ball_reset: 1'b1, game_over: 1'b0, game_win: 1'b0};
      ST_OVER:    o = '{graph_still: 1'b1, ball_reset: 1'b0, game_over: 1'b1, game_win: 1'b0};
      ST_WIN:     o = '{graph_still: 1'b1, ball_reset: 1'b0, game_over: 1'b0, game_win: 1'b1};
      default:    o = '{graph_still: 1'b1, ball_reset: 1'b1, game_over: 1'b0, game_win: 1'b0};
    endcase
    return o;
  endfunction

endpackage

// File: rtl/bcd_score_counter.sv
// Four-digit BCD score with wrap 9999 -> 0000; updates one cycle after clr/inc, clr wins.
// No backpressure: every inc pulse is counted.
module bcd_score_counter (
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        inc,
  output logic [15:0] score
);

  logic [15:0] r_score;
  logic [15:0] w_score_inc;
  logic        w_carry;

  // Ripple the +1 through the digits; a digit at 9 rolls to 0 and passes the carry on.
  always_comb begin
    w_score_inc = r_score;
    w_carry     = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (w_carry) begin
        if (r_score[i*4 +: 4] == 4'd9) begin
          w_score_inc[i*4 +: 4] = 4'd0;
        end else begin
          w_score_inc[i*4 +: 4] = r_score[i*4 +: 4] + 4'd1;
          w_carry               = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      r_score <= '0;
    end else if (inc) begin
      r_score <= w_score_inc;
    end
  end

  assign score = r_score;

endmodule

// File: rtl/brick_game_ctrl_fsm.sv
// Game-flow FSM: new game, play, new ball, game over, win; tracks lives and BCD score.
// State/outputs registered (1 cycle after input), timer_start combinational in the exiting PLAY cycle.
module brick_game_ctrl_fsm
  import brick_game_pkg::*;
#(
  parameter int unsigned LIVES_INIT = LIVES_INIT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn,
  input  logic        ball_miss,
  input  logic        brick_hit,
  input  logic        bricks_cleared,
  input  logic        timer_up_tick,
  output logic        timer_start,
  output logic        graph_still,
  output logic        ball_reset,
  output logic        game_over,
  output logic        game_win,
  output logic [1:0]  lives,
  output logic [15:0] score
);

  localparam logic [1:0] LIVES_LOAD = 2'(LIVES_INIT);

  state_t     r_state;
  state_t     w_next_state;
  logic [1:0] r_lives;
  logic [1:0] w_next_lives;
  logic       r_btn_q;
  ovl_t       r_ovl;
  ovl_t       w_next_ovl;

  logic w_btn_edge;
  logic w_in_play;
  logic w_play_exit;
  logic w_score_clr;
  logic w_score_inc;

  // r_btn_q resets high so a button held through reset is not seen as a press.
  assign w_btn_edge  = btn & ~r_btn_q;
  assign w_in_play   = (r_state == ST_PLAY);
  assign w_play_exit = w_in_play & (bricks_cleared | ball_miss);
  assign w_score_clr = (r_state == ST_NEWGAME) & w_btn_edge;
  assign w_score_inc = w_in_play & brick_hit;

  always_comb begin
    w_next_state = r_state;
    w_next_lives = r_lives;
    case (r_state)
      ST_NEWGAME: begin
        if (w_btn_edge) begin
          w_next_state = ST_PLAY;
          w_next_lives = LIVES_LOAD;
        end
      end
      ST_PLAY: begin
        if (bricks_cleared) begin
          w_next_state = ST_WIN;
        end else if (ball_miss) begin
          if (r_lives > 2'd1) begin
            w_next_state = ST_NEWBALL;
            w_next_lives = r_lives - 2'd1;
          end else begin
            w_next_state = ST_OVER;
            w_next_lives = 2'd0;
          end
        end
      end
      ST_NEWBALL: if (timer_up_tick) w_next_state = ST_PLAY;
      ST_OVER:    if (timer_up_tick) w_next_state = ST_NEWGAME;
      ST_WIN:     if (timer_up_tick) w_next_state = ST_NEWGAME;
      default:    w_next_state = ST_NEWGAME;
    endcase
    w_next_ovl = decode_ovl(w_next_state);
  end

  // Overlay flags are decoded from the next state so they line up with r_state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_NEWGAME;
      r_lives <= LIVES_LOAD;
      r_btn_q <= 1'b1;
      r_ovl   <= decode_ovl(ST_NEWGAME);
    end else begin
      r_state <= w_next_state;
      r_lives <= w_next_lives;
      r_btn_q <= btn;
      r_ovl   <= w_next_ovl;
    end
  end

  bcd_score_counter u_score (
    .clk   (clk),
    .reset (reset),
    .clr   (w_score_clr),
    .inc   (w_score_inc),
    .score (score)
  );

  assign timer_start = w_play_exit;
  assign graph_still = r_ovl.graph_still;
  assign ball_reset  = r_ovl.ball_reset;
  assign game_over   = r_ovl.game_over;
  assign game_win    = r_ovl.game_win;
  assign lives       = r_lives;

endmodule

// File: tb/tb_brick_game_ctrl_fsm.sv
// Directed scoreboard bench for brick_game_ctrl_fsm: stimulus queues expected outputs per cycle,
// a negedge monitor pops and compares them and matches every timer_start pulse to a queued cycle.
module tb_brick_game_ctrl_fsm;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        btn = 1'b0;
  logic        ball_miss = 1'b0;
  logic        brick_hit = 1'b0;
  logic        bricks_cleared = 1'b0;
  logic        timer_up_tick = 1'b0;
  logic        timer_start;
  logic        graph_still;
  logic        ball_reset;
  logic        game_over;
  logic        game_win;
  logic [1:0]  lives;
  logic [15:0] score;

  brick_game_ctrl_fsm #(.LIVES_INIT(3)) dut (
    .clk            (clk),
    .reset          (reset),
    .btn            (btn),
    .ball_miss      (ball_miss),
    .brick_hit      (brick_hit),
    .bricks_cleared (bricks_cleared),
    .timer_up_tick  (timer_up_tick),
    .timer_start    (timer_start),
    .graph_still    (graph_still),
    .ball_reset     (ball_reset),
    .game_over      (game_over),
    .game_win       (game_win),
    .lives          (lives),
    .score          (score)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic        gs;
    logic        br;
    logic        go;
    logic        gw;
    logic [1:0]  lv;
    logic [15:0] sc;
  } exp_t;

  exp_t  exp_q[$];
  string nm_q[$];
  int    ts_q[$];
  int    cyc = 0;
  int    checks = 0;
  int    errors = 0;

  always @(posedge clk) cyc++;

  exp_t  m_e;
  string m_n;
  int    m_tc;

  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      m_e = exp_q.pop_front();
      m_n = nm_q.pop_front();
      checks++;
      if (m_e.cyc != cyc || graph_still !== m_e.gs || ball_reset !== m_e.br ||
          game_over !== m_e.go || game_win !== m_e.gw || lives !== m_e.lv || score !== m_e.sc) begin
        errors++;
        $display("FAIL %s cyc %0d (want cyc %0d): got gs=%b br=%b go=%b gw=%b lives=%0d score=%h, want gs=%b br=%b go=%b gw=%b lives=%0d score=%h",
                 m_n, cyc, m_e.cyc, graph_still, ball_reset, game_over, game_win, lives, score,
                 m_e.gs, m_e.br, m_e.go, m_e.gw, m_e.lv, m_e.sc);
      end
    end
    if (timer_start === 1'b1) begin
      checks++;
      if (ts_q.size() == 0) begin
        errors++;
        $display("FAIL timer_start unexpected at cyc %0d, want no pulse", cyc);
      end else begin
        m_tc = ts_q.pop_front();
        if (m_tc != cyc) begin
          errors++;
          $display("FAIL timer_start at cyc %0d, want cyc %0d", cyc, m_tc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_at(input int dc, input logic gs, input logic br, input logic go,
                           input logic gw, input logic [1:0] lv, input logic [15:0] sc,
                           input string nm);
    exp_t e;
    e.cyc = cyc + dc;
    e.gs = gs; e.br = br; e.go = go; e.gw = gw; e.lv = lv; e.sc = sc;
    exp_q.push_back(e);
    nm_q.push_back(nm);
  endtask

  task automatic ts_expect();
    ts_q.push_back(cyc);
  endtask

  task automatic hits(input int n);
    brick_hit = 1'b1;
    repeat (n) tick();
    brick_hit = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Overlay patterns: NEWGAME/NEWBALL 1100, PLAY 0000, OVER 1010, WIN 1001.
  initial begin
    repeat (3) tick();
    reset = 1'b0;
    expect_at(0, 1, 1, 0, 0, 2'd3, 16'h0000, "reset_state");
    tick();

    btn = 1'b1;
    expect_at(1, 0, 0, 0, 0, 2'd3, 16'h0000, "btn_to_play");
    tick();
    btn = 1'b0;

    timer_up_tick = 1'b1;
    expect_at(1, 0, 0, 0, 0, 2'd3, 16'h0000, "tick_ignored_in_play");
    tick();
    timer_up_tick = 1'b0;

    hits(12);   expect_at(0, 0, 0, 0, 0, 2'd3, 16'h0012, "score_12");
    hits(87);   expect_at(0, 0, 0, 0, 0, 2'd3, 16'h0099, "score_99");
    hits(1);    expect_at(0, 0, 0, 0, 0, 2'd3, 16'h0100, "score_carry_100");
    hits(9899); expect_at(0, 0, 0, 0, 0, 2'd3, 16'h9999, "score_9999");
    hits(1);    expect_at(0, 0, 0, 0, 0, 2'd3, 16'h0000, "score_wrap");

    ball_miss = 1'b1;
    ts_expect();
    expect_at(1, 1, 1, 0, 0, 2'd2, 16'h0000, "miss1_newball");
    tick();
    ball_miss = 1'b0;

    brick_hit = 1'b1; ball_miss = 1'b1; bricks_cleared = 1'b1;
    expect_at(1, 1, 1, 0, 0, 2'd2, 16'h0000, "newball_ignores_play_events");
    tick();
    brick_hit = 1'b0; ball_miss = 1'b0; bricks_cleared = 1'b0;
    repeat (3) tick();
    timer_up_tick = 1'b1;
    expect_at(1, 0, 0, 0, 0, 2'd2, 16'h0000, "newball_to_play");
    tick();
    timer_up_tick = 1'b0;

    ball_miss = 1'b1;
    ts_expect();
    expect_at(1, 1, 1, 0, 0, 2'd1, 16'h0000, "miss2_newball");
    tick();
    ball_miss = 1'b0;
    repeat (3) tick();
    timer_up_tick = 1'b1;
    expect_at(1, 0, 0, 0, 0, 2'd1, 16'h0000, "newball_to_play_2");
    tick();
    timer_up_tick = 1'b0;

    hits(3); expect_at(0, 0, 0, 0, 0, 2'd1, 16'h0003, "score_3");

    ball_miss = 1'b1;
    ts_expect();
    expect_at(1, 1, 0, 1, 0, 2'd0, 16'h0003, "miss3_game_over");
    tick();
    ball_miss = 1'b0;

    btn = 1'b1;
    expect_at(1, 1, 0, 1, 0, 2'd0, 16'h0003, "btn_ignored_in_over");
    tick();
    btn = 1'b0;
    tick();

    timer_up_tick = 1'b1;
    expect_at(1, 1, 1, 0, 0, 2'd0, 16'h0003, "over_to_newgame_score_kept");
    tick();
    timer_up_tick = 1'b0;
    tick();

    btn = 1'b1;
    expect_at(1, 0, 0, 0, 0, 2'd3, 16'h0000, "new_game_clears");
    tick();
    btn = 1'b0;

    bricks_cleared = 1'b1; ball_miss = 1'b1; brick_hit = 1'b1;
    ts_expect();
    expect_at(1, 1, 0, 0, 1, 2'd3, 16'h0001, "win_priority");
    tick();
    bricks_cleared = 1'b0; ball_miss = 1'b0; brick_hit = 1'b0;

    timer_up_tick = 1'b1;
    expect_at(1, 1, 1, 0, 0, 2'd3, 16'h0001, "win_to_newgame");
    tick();
    timer_up_tick = 1'b0;

    btn = 1'b1;
    reset = 1'b1;
    expect_at(1, 1, 1, 0, 0, 2'd3, 16'h0000, "reset_in_newgame");
    tick();
    tick();
    reset = 1'b0;
    repeat (3) tick();
    expect_at(0, 1, 1, 0, 0, 2'd3, 16'h0000, "held_btn_no_start");
    btn = 1'b0;
    tick();
    btn = 1'b1;
    expect_at(1, 0, 0, 0, 0, 2'd3, 16'h0000, "press_after_release");
    tick();
    btn = 1'b0;

    hits(2); expect_at(0, 0, 0, 0, 0, 2'd3, 16'h0002, "score_2");
    ball_miss = 1'b1;
    ts_expect();
    expect_at(1, 1, 1, 0, 0, 2'd2, 16'h0002, "miss_before_reset");
    tick();
    ball_miss = 1'b0;
    tick();

    reset = 1'b1;
    expect_at(1, 1, 1, 0, 0, 2'd3, 16'h0000, "reset_in_newball");
    tick();
    reset = 1'b0;

    timer_up_tick = 1'b1;
    expect_at(1, 1, 1, 0, 0, 2'd3, 16'h0000, "tick_ignored_in_newgame");
    tick();
    timer_up_tick = 1'b0;
    repeat (3) tick();

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expectations left, want 0", exp_q.size());
    end
    checks++;
    if (ts_q.size() != 0) begin
      errors++;
      $display("FAIL timer_start_drain: %0d pulses missing, want 0", ts_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
